// File: rtl/city_loader.sv
// city_loader: builds a set of N_CITIES unique (x,y) coordinates for the TSP core
// from a user-seeded 16-bit Galois LFSR. It draws candidates in pairs and scans the
// cities already accepted to reject duplicates. valid is raised once the set is complete.
module city_loader #(
  parameter int          N_CITIES     = 64,
  parameter int          COORD_W      = 8,
  parameter logic [15:0] LFSR_TAPS    = 16'hB400,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1,
  localparam int         IDX_W        = $clog2(N_CITIES),
  localparam int         CNT_W        = $clog2(N_CITIES + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load,
  input  logic [15:0]                        seed,
  output logic [N_CITIES-1:0][COORD_W-1:0]   xs,
  output logic [N_CITIES-1:0][COORD_W-1:0]   ys,
  output logic                               valid,
  output logic                               busy,
  output logic [CNT_W-1:0]                   count
);

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    GEN_X,
    GEN_Y,
    CHECK,
    WRITE,
    DONE
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [15:0]          lfsr;
  logic [15:0]          lfsr_next;
  logic [15:0]          seed_q;
  logic [COORD_W-1:0]   cand_x;
  logic [COORD_W-1:0]   cand_y;
  logic [IDX_W-1:0]     j;
  logic                 load_ok;
  logic                 scan_end;
  logic                 hit;
  logic                 last;

  // One right-shifting Galois step; the feedback mask is applied when a 1 falls out.
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);

  // The scan ends when j reaches the number of stored cities; an empty set ends at once.
  assign scan_end = (CNT_W'(j) == count);
  assign hit      = (xs[j] == cand_x) && (ys[j] == cand_y);
  assign last     = (count == CNT_W'(N_CITIES - 1));
  assign load_ok  = load && ((state_q == IDLE) || (state_q == DONE));
  assign busy     = (state_q != IDLE) && (state_q != DONE);

  // State register; reset drops straight back to IDLE even mid-generation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; load is honoured only while idle or done, never queued.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load) state_d = SEED;
      SEED:    state_d = GEN_X;
      GEN_X:   state_d = GEN_Y;
      GEN_Y:   state_d = CHECK;
      CHECK: begin
        if (scan_end) state_d = WRITE;
        else if (hit) state_d = GEN_X;
      end
      WRITE:   state_d = last ? DONE : GEN_X;
      DONE:    if (load) state_d = SEED;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: seed capture, LFSR stepping, duplicate scan, and the city arrays.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr   <= DEFAULT_SEED;
      seed_q <= '0;
      cand_x <= '0;
      cand_y <= '0;
      j      <= '0;
      count  <= '0;
      valid  <= 1'b0;
      xs     <= '0;
      ys     <= '0;
    end else begin
      if (load_ok) seed_q <= seed;
      unique case (state_q)
        SEED: begin
          lfsr  <= (seed_q == 16'h0000) ? DEFAULT_SEED : seed_q;
          count <= '0;
          valid <= 1'b0;
        end
        GEN_X: begin
          lfsr   <= lfsr_next;
          cand_x <= lfsr_next[COORD_W-1:0];
        end
        GEN_Y: begin
          lfsr   <= lfsr_next;
          cand_y <= lfsr_next[COORD_W-1:0];
          j      <= '0;
        end
        CHECK: begin
          if (!scan_end && !hit) j <= j + IDX_W'(1);
        end
        WRITE: begin
          xs[count[IDX_W-1:0]] <= cand_x;
          ys[count[IDX_W-1:0]] <= cand_y;
          count                <= count + CNT_W'(1);
        end
        DONE:    valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_city_loader.sv
// Testbench for city_loader: directed runs with several seeds, checked against a
// behavioural model of the generator, plus reset, ignored-load and restart cases.
module tb_city_loader;

  logic              clk = 1'b0;
  logic              rst;
  logic              load;
  logic [15:0]       seed;
  logic [63:0][7:0]  xs;
  logic [63:0][7:0]  ys;
  logic              valid;
  logic              busy;
  logic [6:0]        count;

  int                total = 0;
  int                bad   = 0;
  logic [511:0]      exp_xs;
  logic [511:0]      exp_ys;
  int                exp_cost;

  city_loader dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .seed  (seed),
    .xs    (xs),
    .ys    (ys),
    .valid (valid),
    .busy  (busy),
    .count (count)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    logic b;
    b = v[0];
    v = v >> 1;
    if (b) v = v ^ 16'hB400;
    return v;
  endfunction

  // Reference generator: expected city set and busy-cycle cost after SEED for a seed.
  task automatic modelRun(input logic [15:0] s);
    logic [15:0] l;
    logic [7:0]  cx;
    logic [7:0]  cy;
    int          n;
    int          hitAt;
    l = s;
    n = 0;
    exp_cost = 0;
    exp_xs = '0;
    exp_ys = '0;
    while (n < 64) begin
      l  = lfsrStep(l);
      cx = l[7:0];
      l  = lfsrStep(l);
      cy = l[7:0];
      hitAt = -1;
      for (int k = 0; k < n; k++)
        if (hitAt < 0 && exp_xs[k*8 +: 8] == cx && exp_ys[k*8 +: 8] == cy) hitAt = k;
      if (hitAt >= 0) exp_cost += 3 + hitAt;
      else begin
        exp_xs[n*8 +: 8] = cx;
        exp_ys[n*8 +: 8] = cy;
        exp_cost += 4 + n;
        n++;
      end
    end
  endtask

  // Pulse load, then follow the run until busy drops; optionally pulse load again mid-run.
  task automatic applyStimulus(input logic [15:0] s, input int pulseAt, output int busyCycles);
    bit pulsed;
    pulsed = 0;
    @(negedge clk);
    seed = s;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    busyCycles = 0;
    while (busy === 1'b1 && busyCycles < 20000) begin
      busyCycles++;
      if (busyCycles == 6) checkOutput("count_after_first_write", count, 1);
      if (pulseAt >= 0 && !pulsed && count == pulseAt) begin
        load = 1'b1;
        pulsed = 1;
      end else load = 1'b0;
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  function automatic int dupPairs();
    int d;
    d = 0;
    for (int a = 0; a < 64; a++)
      for (int b = a + 1; b < 64; b++)
        if (xs[a] == xs[b] && ys[a] == ys[b]) d++;
    return d;
  endfunction

  // Full run with model comparison, exact completion timing, and uniqueness check.
  task automatic runAndCheck(input string tag, input logic [15:0] s, input logic [15:0] modelSeed,
                             input int pulseAt);
    int bc;
    modelRun(modelSeed);
    applyStimulus(s, pulseAt, bc);
    checkOutput({tag, "_busy_cycles"}, bc, 1 + exp_cost);
    checkOutput({tag, "_valid_low_on_done"}, valid, 0);
    @(negedge clk);
    checkOutput({tag, "_valid_rise"}, valid, 1);
    checkOutput({tag, "_busy_done"}, busy, 0);
    checkOutput({tag, "_count"}, count, 64);
    checkOutput({tag, "_xs"}, xs, exp_xs);
    checkOutput({tag, "_ys"}, ys, exp_ys);
    checkOutput({tag, "_dups"}, dupPairs(), 0);
  endtask

  initial begin
    int n;
    int rises;
    int high;
    int riseCyc[2];
    logic prev;

    rst  = 1'b0;
    load = 1'b0;
    seed = 16'h0000;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_count", count, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_xs", xs, '0);

    // Reference seed: city 0 hand-derived from ACE1 -> E270 -> 7138.
    runAndCheck("ace1", 16'hACE1, 16'hACE1, -1);
    checkOutput("ace1_city0_x", xs[0], 8'h70);
    checkOutput("ace1_city0_y", ys[0], 8'h38);

    // Seed 0 falls back to the default seed.
    runAndCheck("seed0", 16'h0000, 16'hACE1, -1);
    runAndCheck("s0001", 16'h0001, 16'h0001, -1);
    runAndCheck("sffff", 16'hFFFF, 16'hFFFF, -1);
    runAndCheck("s1234", 16'h1234, 16'h1234, -1);

    // Mid-run reset clears everything asynchronously.
    @(negedge clk);
    seed = 16'h1234;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (count < 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrun_reached", (count >= 3), 1);
    rst = 1'b0;
    #1;
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_count", count, 0);
    checkOutput("async_rst_valid", valid, 0);
    checkOutput("async_rst_xs", xs, '0);
    checkOutput("async_rst_ys", ys, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_count", count, 0);

    // Load pulsed while busy at count 10 must not disturb the run.
    runAndCheck("pulse10", 16'hACE1, 16'hACE1, 10);

    // Load accepted in DONE: valid drops one cycle later and count restarts.
    load = 1'b1;
    seed = 16'h0001;
    @(negedge clk);
    load = 1'b0;
    checkOutput("restart_busy", busy, 1);
    checkOutput("restart_valid_seed_cycle", valid, 1);
    @(negedge clk);
    checkOutput("restart_valid_drop", valid, 0);
    checkOutput("restart_count", count, 0);
    modelRun(16'h0001);
    n = 0;
    while (busy === 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput("restart_valid", valid, 1);
    checkOutput("restart_xs", xs, exp_xs);

    // Load held high: back-to-back runs, valid high exactly one cycle per run.
    modelRun(16'hACE1);
    seed = 16'hACE1;
    load = 1'b1;
    rises = 0;
    high = 0;
    riseCyc[0] = 0;
    riseCyc[1] = 0;
    prev = valid;
    n = 0;
    while (rises < 2 && n < 12000) begin
      @(negedge clk);
      n++;
      if (valid && !prev) begin
        riseCyc[rises] = n;
        rises++;
      end
      if (rises > 0 && valid) high++;
      prev = valid;
    end
    repeat (3) begin
      @(negedge clk);
      if (valid) high++;
    end
    load = 1'b0;
    checkOutput("held_rises", rises, 2);
    checkOutput("held_high_cycles", high, 2);
    checkOutput("held_period", riseCyc[1] - riseCyc[0], exp_cost + 2);
    n = 0;
    while (busy === 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput("held_final_xs", xs, exp_xs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
